// File: rtl/ap_pkg.sv
// ---------------------------------------------------------------------------
// ap_pkg
// Definitions shared by the associative-processor blocks that sit around the
// result CAM array:
//   - read/operation mode codes driven onto the array's mode input
//   - park offset: an address of (size + PARK_OFFSET) disables array output
//   - writeback sequencer state encoding
// ---------------------------------------------------------------------------
package ap_pkg;

    localparam logic [2:0] RowxRow = 3'd1;
    localparam logic [2:0] ColxCol = 3'd2;
    localparam logic [2:0] COPY_B  = 3'd3;
    localparam logic [2:0] COPY_R  = 3'd4;
    localparam logic [2:0] COPY_A  = 3'd5;
    localparam logic [2:0] RST0    = 3'd6;

    localparam int PARK_OFFSET = 3;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock show-ahead FIFO: head always presents the oldest entry while
// the FIFO is not empty. Push and pop on the same edge are both performed.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset (pointers and count)
//   push       write push_data this edge
//   push_data  entry to store
//   pop        discard the head entry this edge (ignored when empty)
//   head       oldest entry (show-ahead)
//   empty      no entries stored
//   count      number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only harmless when the head leaves on the
    // same edge; otherwise it is dropped and flagged by the assertion below.
    assign do_push = push && (!full || do_pop);
    assign head    = storage[rd_ptr];

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            storage[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && full));

endmodule

// File: rtl/cam_result_writeback.sv
// ---------------------------------------------------------------------------
// cam_result_writeback
// Streams every row (or column) out of the result CAM array after an
// associative operation and writes each word to data memory at
// base_addr + index through a valid/ready handshake.
//
// Ports:
//   clk, rst                  clock; asynchronous active-low reset
//   start, col_sel, base_addr request (sampled in IDLE only): readout
//                             direction and first memory address
//   busy, done                operation in progress / one-cycle completion
//   mode_out                  array read mode (RowxRow / ColxCol, 0 idle)
//   addr_output_Row/_Col      array read addresses (parked when unused)
//   Q_out_row, Q_out_col      registered array read data
//   mem_wr_en, mem_addr,      memory write request; held stable until
//   mem_wdata, mem_ready      mem_ready accepts it
// ---------------------------------------------------------------------------
module cam_result_writeback
    import ap_pkg::*;
#(
    parameter int DATA_WIDTH     = 4,
    parameter int DATA_DEPTH     = 4,
    parameter int ADDR_WIDTH_CAM = 8,
    parameter int ADDR_WIDTH_MEM = 16,
    parameter int MEM_WIDTH      = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      col_sel,
    input  logic [ADDR_WIDTH_MEM-1:0] base_addr,
    output logic                      busy,
    output logic                      done,
    output logic [2:0]                mode_out,
    output logic [ADDR_WIDTH_CAM-1:0] addr_output_Row,
    output logic [ADDR_WIDTH_CAM-1:0] addr_output_Col,
    input  logic [DATA_WIDTH-1:0]     Q_out_row,
    input  logic [DATA_DEPTH-1:0]     Q_out_col,
    output logic                      mem_wr_en,
    output logic [ADDR_WIDTH_MEM-1:0] mem_addr,
    output logic [MEM_WIDTH-1:0]      mem_wdata,
    input  logic                      mem_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int OW = CW + 2;

    localparam logic [ADDR_WIDTH_CAM-1:0] ROW_PARK = ADDR_WIDTH_CAM'(DATA_DEPTH + PARK_OFFSET);
    localparam logic [ADDR_WIDTH_CAM-1:0] COL_PARK = ADDR_WIDTH_CAM'(DATA_WIDTH + PARK_OFFSET);
    localparam logic [ADDR_WIDTH_CAM-1:0] ROW_LAST = ADDR_WIDTH_CAM'(DATA_DEPTH - 1);
    localparam logic [ADDR_WIDTH_CAM-1:0] COL_LAST = ADDR_WIDTH_CAM'(DATA_WIDTH - 1);

    state_t                    state;
    logic                      col_sel_q;
    logic [ADDR_WIDTH_MEM-1:0] base_q;
    logic [ADDR_WIDTH_CAM-1:0] last_idx;
    logic [ADDR_WIDTH_CAM-1:0] rd_idx;
    logic [ADDR_WIDTH_CAM-1:0] wr_idx;

    // One flag per outstanding array read: p0 = address just registered,
    // p2 = data present on Q_out_* and captured on the coming edge.
    logic vld_p0;
    logic vld_p1;
    logic vld_p2;

    logic [CW-1:0]             fifo_count;
    logic                      fifo_empty;
    logic [MEM_WIDTH-1:0]      fifo_head;
    logic [MEM_WIDTH-1:0]      capture_data;
    logic [1:0]                inflight;
    logic [OW-1:0]             occupancy;
    logic [ADDR_WIDTH_CAM-1:0] cur_idx;
    logic [ADDR_WIDTH_CAM-1:0] cur_last;
    logic                      cur_col;
    logic                      issue;
    logic                      fire;

    assign mem_wr_en = !fifo_empty;
    assign mem_addr  = base_q + ADDR_WIDTH_MEM'(wr_idx);
    assign mem_wdata = fifo_empty ? '0 : fifo_head;

    always_comb begin
        inflight  = {1'b0, vld_p0} + {1'b0, vld_p1} + {1'b0, vld_p2};
        occupancy = OW'(fifo_count) + OW'(inflight);
        // The first index goes out on the same edge that accepts start, so
        // in IDLE the request inputs stand in for the not-yet-latched copies.
        cur_idx   = (state == IDLE) ? '0 : rd_idx;
        cur_col   = (state == IDLE) ? col_sel : col_sel_q;
        cur_last  = (state == IDLE) ? (col_sel ? COL_LAST : ROW_LAST) : last_idx;
        // Credit: every issued read already owns a FIFO slot, so a capture
        // can never find the FIFO full.
        issue     = (((state == IDLE) && start) || (state == READ))
                    && (occupancy < OW'(FIFO_DEPTH));
        fire      = mem_wr_en && mem_ready;
        capture_data = col_sel_q ? MEM_WIDTH'(Q_out_col) : MEM_WIDTH'(Q_out_row);
    end

    sync_fifo #(
        .WIDTH (MEM_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_capture_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (vld_p2),
        .push_data (capture_data),
        .pop       (fire),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            mode_out        <= 3'd0;
            addr_output_Row <= ROW_PARK;
            addr_output_Col <= COL_PARK;
            col_sel_q       <= 1'b0;
            base_q          <= '0;
            last_idx        <= '0;
            rd_idx          <= '0;
            wr_idx          <= '0;
            vld_p0          <= 1'b0;
            vld_p1          <= 1'b0;
            vld_p2          <= 1'b0;
        end else begin
            // ---- stage p0: address issue; p1/p2: array read latency ----
            vld_p0 <= issue;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;

            addr_output_Row <= ROW_PARK;
            addr_output_Col <= COL_PARK;
            if (issue) begin
                if (cur_col) begin
                    addr_output_Col <= cur_idx;
                end else begin
                    addr_output_Row <= cur_idx;
                end
            end

            if (fire) begin
                wr_idx <= wr_idx + ADDR_WIDTH_CAM'(1);
            end

            done <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        col_sel_q <= col_sel;
                        base_q    <= base_addr;
                        last_idx  <= cur_last;
                        wr_idx    <= '0;
                        busy      <= 1'b1;
                        mode_out  <= col_sel ? ColxCol : RowxRow;
                        rd_idx    <= issue ? ADDR_WIDTH_CAM'(1) : '0;
                        state     <= (issue && (cur_last == '0)) ? DRAIN : READ;
                    end
                end
                READ: begin
                    if (issue) begin
                        rd_idx <= rd_idx + ADDR_WIDTH_CAM'(1);
                        if (rd_idx == last_idx) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (fire && (wr_idx == last_idx)) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        mode_out <= 3'd0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
